// File: rtl/wash_payment.sv
// -----------------------------------------------------------------------------
// wash_payment
//
// Point-of-sale front end for the car wash controller. Collects coins into a
// credit balance (in quarter units), validates a wash selection against its
// price, drives selection/approvalStatus into the carwash block, holds the
// approval until the carwash reports completion and then refunds any credit
// that is left over. An idle timeout in COLLECT returns the credit to a
// customer who walked away.
//
// Ports
//   clk            : system clock (shared with the carwash block)
//   reset          : synchronous, active-low reset
//   coin_valid     : one-cycle coin insert strobe
//   coin_value     : 0 = quarter (1), 1 = dollar (4), 2 = five (20), 3 = invalid
//   select_valid   : one-cycle wash button strobe
//   select_in      : requested wash 1..3 (0 is invalid)
//   cancel         : customer cancel strobe
//   wash_complete  : carwash "complete" indication
//   selection      : wash selection presented to the carwash
//   approvalStatus : wash approved, held until completion
//   credit         : current credit in quarters
//   change         : refund amount, meaningful while change_valid is high
//   change_valid   : one-cycle refund strobe
//   coin_reject    : one-cycle strobe, coin returned and not credited
//   error          : one-cycle strobe, invalid or under-funded selection
//   state          : FSM state for debug (IDLE=0, COLLECT=1, APPROVED=2,
//                    REFUND=3)
// -----------------------------------------------------------------------------
module wash_payment #(
    parameter logic [7:0] PRICE1  = 8'd20,
    parameter logic [7:0] PRICE2  = 8'd32,
    parameter logic [7:0] PRICE3  = 8'd48,
    parameter int         TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select_in,
    input  logic       cancel,
    input  logic       wash_complete,
    output logic [1:0] selection,
    output logic       approvalStatus,
    output logic [7:0] credit,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_APPROVED = 3'd2,
        ST_REFUND   = 3'd3
    } state_e;

    // Idle counter only has to reach TIMEOUT, so size it for that value.
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);

    // Coin code to credit value in quarters; the invalid code is worth nothing.
    function automatic logic [7:0] coin_amount(input logic [1:0] code);
        logic [7:0] amt;
        case (code)
            2'd0:    amt = 8'd1;
            2'd1:    amt = 8'd4;
            2'd2:    amt = 8'd20;
            default: amt = 8'd0;
        endcase
        return amt;
    endfunction

    // Wash code to price in quarters; code 0 never gets funded (see sel_ok_s).
    function automatic logic [7:0] wash_price(input logic [1:0] sel);
        logic [7:0] p;
        case (sel)
            2'd1:    p = PRICE1;
            2'd2:    p = PRICE2;
            2'd3:    p = PRICE3;
            default: p = 8'd0;
        endcase
        return p;
    endfunction

    state_e           state_q;
    logic [7:0]       credit_q;
    logic [7:0]       change_q;
    logic [1:0]       selection_q;
    logic             approval_q;
    logic             change_valid_q;
    logic             coin_reject_q;
    logic             error_q;
    logic             armed_q;
    logic [CNT_W-1:0] idle_cnt_q;

    logic [8:0]       coin_sum_s;
    logic             coin_ok_s;
    logic [7:0]       price_s;
    logic             sel_ok_s;

    // Coin and selection qualification shared by IDLE and COLLECT.
    always_comb begin
        coin_sum_s = {1'b0, credit_q} + {1'b0, coin_amount(coin_value)};
        // Bit 8 set means the sum passed 255: reject rather than wrap.
        coin_ok_s  = (coin_value != 2'd3) && !coin_sum_s[8];
        price_s    = wash_price(select_in);
        sel_ok_s   = (select_in != 2'd0) && (credit_q >= price_s);
    end

    // Payment FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // Credit held at reset is dropped, not refunded.
            state_q        <= ST_IDLE;
            credit_q       <= 8'd0;
            change_q       <= 8'd0;
            selection_q    <= 2'd0;
            approval_q     <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            error_q        <= 1'b0;
            armed_q        <= 1'b0;
            idle_cnt_q     <= CNT_ZERO;
        end else begin
            // Strobes are one cycle wide unless re-asserted below.
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            error_q        <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // select_valid and cancel have no meaning without credit.
                    if (coin_valid) begin
                        if (coin_ok_s) begin
                            credit_q   <= coin_sum_s[7:0];
                            idle_cnt_q <= CNT_ZERO;
                            state_q    <= ST_COLLECT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= CNT_ZERO;
                    end
                end

                ST_COLLECT: begin
                    if (cancel) begin
                        // A coin in the same cycle loses to the cancel.
                        coin_reject_q <= coin_valid;
                        idle_cnt_q    <= CNT_ZERO;
                        state_q       <= ST_REFUND;
                    end else if (select_valid) begin
                        coin_reject_q <= coin_valid;
                        idle_cnt_q    <= CNT_ZERO;
                        if (sel_ok_s) begin
                            selection_q <= select_in;
                            credit_q    <= credit_q - price_s;
                            approval_q  <= 1'b1;
                            armed_q     <= 1'b0;
                            state_q     <= ST_APPROVED;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        idle_cnt_q <= CNT_ZERO;
                        if (coin_ok_s) begin
                            credit_q <= coin_sum_s[7:0];
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // This quiet cycle is the TIMEOUT-th one in a row.
                        idle_cnt_q <= CNT_ZERO;
                        state_q    <= ST_REFUND;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_ONE;
                    end
                end

                ST_APPROVED: begin
                    coin_reject_q <= coin_valid;
                    // armed_q guards against a complete left high by the
                    // previous wash; only a 0-then-1 ends this wash.
                    if (wash_complete && armed_q) begin
                        approval_q  <= 1'b0;
                        selection_q <= 2'd0;
                        armed_q     <= 1'b0;
                        if (credit_q != 8'd0) begin
                            state_q <= ST_REFUND;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!wash_complete) begin
                        armed_q <= 1'b1;
                    end else begin
                        armed_q <= armed_q;
                    end
                end

                ST_REFUND: begin
                    coin_reject_q  <= coin_valid;
                    change_q       <= credit_q;
                    change_valid_q <= 1'b1;
                    credit_q       <= 8'd0;
                    state_q        <= ST_IDLE;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    approval_q  <= 1'b0;
                    selection_q <= 2'd0;
                    armed_q     <= 1'b0;
                    idle_cnt_q  <= CNT_ZERO;
                end
            endcase
        end
    end

    assign selection      = selection_q;
    assign approvalStatus = approval_q;
    assign credit         = credit_q;
    assign change         = change_q;
    assign change_valid   = change_valid_q;
    assign coin_reject    = coin_reject_q;
    assign error          = error_q;
    assign state          = state_q;

endmodule
